// File: rtl/ddr_req_pkg.sv
// Shared command codes, arbiter state encoding and client-id sizing for the DDR request arbiter.
package ddr_req_pkg;

    localparam logic [2:0] CMD_WRITE = 3'b000;
    localparam logic [2:0] CMD_READ  = 3'b001;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_WLOCK = 1'b1
    } state_t;

    // Width of a client id; never narrower than one bit.
    function automatic int cid_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/req_tag_fifo.sv
// In-order FIFO of client ids for outstanding read bursts.
// Latency: head is combinational from storage; push/pop take effect at the next edge.
// Backpressure: full/empty flags; a push while full is taken only when a pop happens the same cycle.
module req_tag_fifo #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_vld,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop_vld,
    output logic [WIDTH-1:0] head_dat,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop   = pop_vld & ~empty;
    assign do_push  = push_vld & (~full | do_pop);
    assign head_dat = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_dat;
    end

endmodule

// File: rtl/ddr_request_arbiter.sv
// N-client arbiter onto the shared DDR address/write-data/read-data FIFOs.
// Latency: zero; grant, forwarding and read-return steering are combinational.
// Backpressure: per-client af/wdf full flags; write data locked to the writer until BEATS beats.
module ddr_request_arbiter
    import ddr_req_pkg::*;
#(
    parameter int NUM_CLIENTS   = 4,
    parameter int ADDR_W        = 31,
    parameter int DATA_W        = 128,
    parameter int MASK_W        = 16,
    parameter int BEATS         = 2,
    parameter int TAG_DEPTH     = 8,
    parameter int PRIORITY_MODE = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_CLIENTS-1:0]        c_af_wr_en,
    input  logic [3*NUM_CLIENTS-1:0]      c_af_cmd_din,
    input  logic [ADDR_W*NUM_CLIENTS-1:0] c_addr_din,
    input  logic [NUM_CLIENTS-1:0]        c_wdf_wr_en,
    input  logic [DATA_W*NUM_CLIENTS-1:0] c_wdf_din,
    input  logic [MASK_W*NUM_CLIENTS-1:0] c_wdf_mask,
    input  logic [NUM_CLIENTS-1:0]        c_rdf_rd_en,
    output logic [NUM_CLIENTS-1:0]        c_af_full,
    output logic [NUM_CLIENTS-1:0]        c_wdf_full,
    output logic [NUM_CLIENTS-1:0]        c_rdf_valid,
    input  logic                          af_full,
    input  logic                          wdf_full,
    input  logic                          rdf_valid,
    output logic                          af_wr_en,
    output logic [2:0]                    af_cmd_din,
    output logic [ADDR_W-1:0]             addr_din,
    output logic                          wdf_wr_en,
    output logic [DATA_W-1:0]             wdf_din,
    output logic [MASK_W-1:0]             wdf_mask_din,
    output logic                          rdf_rd_en,
    output logic                          orphan_err
);
    localparam int CID_W = cid_width(NUM_CLIENTS);
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CID_W-1:0] LAST_ID   = CID_W'(NUM_CLIENTS - 1);
    localparam logic [BW-1:0]    LAST_BEAT = BW'(BEATS - 1);

    state_t           state, state_nx;
    logic [CID_W-1:0] rr_ptr, owner, gnt_id, wr_owner, tag_head;
    logic [BW-1:0]    wbeat, rbeat;
    logic [2:0]       gnt_cmd;
    logic             gnt_is_rd, gnt_is_wr, gnt_stall, accept;
    logic             wr_open, wlast, rd_vld;
    logic             tag_full, tag_empty, tag_push, tag_pop;

    function automatic logic [CID_W-1:0] next_id(input logic [CID_W-1:0] id);
        return (id == LAST_ID) ? '0 : id + 1'b1;
    endfunction

    // With no requester the grant rests on rr_ptr (or 0), so that port alone reports ready.
    always_comb begin
        int idx;
        idx    = 0;
        gnt_id = (PRIORITY_MODE == 0) ? rr_ptr : '0;
        for (int k = NUM_CLIENTS - 1; k >= 0; k--) begin
            if (PRIORITY_MODE == 0) begin
                idx = int'(rr_ptr) + k;
                if (idx >= NUM_CLIENTS) idx = idx - NUM_CLIENTS;
            end else begin
                idx = k;
            end
            if (c_af_wr_en[CID_W'(idx)]) gnt_id = CID_W'(idx);
        end
    end

    assign gnt_cmd   = c_af_cmd_din[int'(gnt_id)*3 +: 3];
    assign gnt_is_rd = (gnt_cmd == CMD_READ);
    assign gnt_is_wr = (gnt_cmd == CMD_WRITE);
    // A full tag FIFO still takes a read in the cycle its head dequeues.
    assign gnt_stall = af_full | (gnt_is_rd & tag_full & ~tag_pop);
    assign accept    = (state == ST_IDLE) & c_af_wr_en[gnt_id] & ~gnt_stall;

    assign wr_owner  = (state == ST_WLOCK) ? owner : gnt_id;
    assign wr_open   = (state == ST_WLOCK) | (accept & gnt_is_wr);
    assign wdf_wr_en = wr_open & c_wdf_wr_en[wr_owner] & ~wdf_full;
    assign wlast     = wdf_wr_en & (wbeat == LAST_BEAT);

    assign tag_push  = accept & gnt_is_rd;
    assign rd_vld    = rdf_valid & ~tag_empty;
    assign rdf_rd_en = rd_vld & c_rdf_rd_en[tag_head];
    assign tag_pop   = rdf_rd_en & (rbeat == LAST_BEAT);

    req_tag_fifo #(
        .WIDTH (CID_W),
        .DEPTH (TAG_DEPTH)
    ) u_tag_fifo (
        .clk      (clk),
        .rst      (rst),
        .push_vld (tag_push),
        .push_dat (gnt_id),
        .pop_vld  (tag_pop),
        .head_dat (tag_head),
        .full     (tag_full),
        .empty    (tag_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (state == ST_IDLE) begin
            if (accept & gnt_is_wr & ~wlast) state_nx = ST_WLOCK;
        end else begin
            if (wlast) state_nx = ST_IDLE;
        end
    end

    always_comb begin
        c_af_full   = '1;
        c_wdf_full  = '1;
        c_rdf_valid = '0;
        if (state == ST_IDLE) c_af_full[gnt_id] = gnt_stall;
        if (wr_open)          c_wdf_full[wr_owner] = wdf_full;
        c_rdf_valid[tag_head] = rd_vld;
        af_wr_en     = accept;
        af_cmd_din   = accept ? gnt_cmd : '0;
        addr_din     = accept ? c_addr_din[int'(gnt_id)*ADDR_W +: ADDR_W] : '0;
        wdf_din      = wdf_wr_en ? c_wdf_din[int'(wr_owner)*DATA_W +: DATA_W] : '0;
        wdf_mask_din = wdf_wr_en ? c_wdf_mask[int'(wr_owner)*MASK_W +: MASK_W] : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr     <= '0;
            owner      <= '0;
            wbeat      <= '0;
            rbeat      <= '0;
            orphan_err <= 1'b0;
        end else begin
            if (accept & gnt_is_wr) owner <= gnt_id;
            // The round-robin pointer moves past a writer only once its burst completes.
            if (wlast)                     rr_ptr <= next_id(wr_owner);
            else if (accept & ~gnt_is_wr)  rr_ptr <= next_id(gnt_id);
            if (wdf_wr_en) wbeat <= wlast ? '0 : wbeat + 1'b1;
            if (rdf_rd_en) rbeat <= tag_pop ? '0 : rbeat + 1'b1;
            if (rdf_valid & tag_empty) orphan_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ddr_request_arbiter.sv
// Bench for ddr_request_arbiter: reset-relative vector table, scoreboarded command and
// write-data streams, and cycle sequences for locking, tag-FIFO and return-path cases.
module tb_ddr_request_arbiter;
    import ddr_req_pkg::*;

    localparam int N  = 4;
    localparam int AW = 31;
    localparam int DW = 128;
    localparam int MW = 16;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    c_af_wr_en, c_wdf_wr_en, c_rdf_rd_en;
    logic [3*N-1:0]  c_af_cmd_din;
    logic [AW*N-1:0] c_addr_din;
    logic [DW*N-1:0] c_wdf_din;
    logic [MW*N-1:0] c_wdf_mask;
    logic            af_full, wdf_full, rdf_valid;

    logic [N-1:0]  c_af_full, c_wdf_full, c_rdf_valid;
    logic          af_wr_en, wdf_wr_en, rdf_rd_en, orphan_err;
    logic [2:0]    af_cmd_din;
    logic [AW-1:0] addr_din;
    logic [DW-1:0] wdf_din;
    logic [MW-1:0] wdf_mask_din;

    logic [N-1:0]  m1_c_af_full, m1_c_wdf_full, m1_c_rdf_valid;
    logic          m1_af_wr_en, m1_wdf_wr_en, m1_rdf_rd_en, m1_orphan_err;
    logic [2:0]    m1_af_cmd_din;
    logic [AW-1:0] m1_addr_din;
    logic [DW-1:0] m1_wdf_din;
    logic [MW-1:0] m1_wdf_mask_din;

    ddr_request_arbiter #(.PRIORITY_MODE(0)) dut (
        .clk(clk), .rst(rst),
        .c_af_wr_en(c_af_wr_en), .c_af_cmd_din(c_af_cmd_din), .c_addr_din(c_addr_din),
        .c_wdf_wr_en(c_wdf_wr_en), .c_wdf_din(c_wdf_din), .c_wdf_mask(c_wdf_mask),
        .c_rdf_rd_en(c_rdf_rd_en), .c_af_full(c_af_full), .c_wdf_full(c_wdf_full),
        .c_rdf_valid(c_rdf_valid), .af_full(af_full), .wdf_full(wdf_full), .rdf_valid(rdf_valid),
        .af_wr_en(af_wr_en), .af_cmd_din(af_cmd_din), .addr_din(addr_din),
        .wdf_wr_en(wdf_wr_en), .wdf_din(wdf_din), .wdf_mask_din(wdf_mask_din),
        .rdf_rd_en(rdf_rd_en), .orphan_err(orphan_err)
    );

    ddr_request_arbiter #(.PRIORITY_MODE(1)) dut_m1 (
        .clk(clk), .rst(rst),
        .c_af_wr_en(c_af_wr_en), .c_af_cmd_din(c_af_cmd_din), .c_addr_din(c_addr_din),
        .c_wdf_wr_en(c_wdf_wr_en), .c_wdf_din(c_wdf_din), .c_wdf_mask(c_wdf_mask),
        .c_rdf_rd_en(c_rdf_rd_en), .c_af_full(m1_c_af_full), .c_wdf_full(m1_c_wdf_full),
        .c_rdf_valid(m1_c_rdf_valid), .af_full(af_full), .wdf_full(wdf_full), .rdf_valid(rdf_valid),
        .af_wr_en(m1_af_wr_en), .af_cmd_din(m1_af_cmd_din), .addr_din(m1_addr_din),
        .wdf_wr_en(m1_wdf_wr_en), .wdf_din(m1_wdf_din), .wdf_mask_din(m1_wdf_mask_din),
        .rdf_rd_en(m1_rdf_rd_en), .orphan_err(m1_orphan_err)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct packed { logic [2:0] cmd; logic [AW-1:0] addr; } cmd_t;
    typedef struct packed { logic [DW-1:0] d; logic [MW-1:0] m; } wd_t;
    cmd_t cmd_q[$];
    wd_t  wd_q[$];
    cmd_t sb_c;
    wd_t  sb_w;

    function automatic logic [DW-1:0] wd(input int c, input int b);
        return {16'hD000 + 16'(c), 16'(b), 96'h0123_4567_89AB_CDEF_F00D_BEEF};
    endfunction

    function automatic logic [MW-1:0] wm(input int c, input int b);
        return 16'(c * 16 + b + 1);
    endfunction

    task automatic exp_cmd(input int c, input logic rd);
        cmd_t e;
        e.cmd  = rd ? CMD_READ : CMD_WRITE;
        e.addr = AW'(c * 256);
        cmd_q.push_back(e);
    endtask

    task automatic exp_wd(input int c, input int b);
        wd_t e;
        e.d = wd(c, b);
        e.m = wm(c, b);
        wd_q.push_back(e);
    endtask

    task automatic drive_req(input logic [N-1:0] req, input logic [N-1:0] rd);
        c_af_wr_en = req;
        for (int i = 0; i < N; i++) c_af_cmd_din[3*i +: 3] = rd[i] ? CMD_READ : CMD_WRITE;
    endtask

    task automatic drive_wd(input logic [N-1:0] vld, input int b);
        c_wdf_wr_en = vld;
        for (int i = 0; i < N; i++) begin
            c_wdf_din[i*DW +: DW]  = wd(i, b);
            c_wdf_mask[i*MW +: MW] = wm(i, b);
        end
    endtask

    task automatic clear_inputs();
        c_af_wr_en = '0; c_af_cmd_din = '0; c_wdf_wr_en = '0; c_rdf_rd_en = '0;
        c_wdf_din = '0; c_wdf_mask = '0; af_full = 1'b0; wdf_full = 1'b0; rdf_valid = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk); #1;
    endtask

    // Every forwarded command and write beat must match the head of the expected stream.
    always @(negedge clk) begin
        if (!rst && af_wr_en) begin
            if (cmd_q.size() == 0) begin
                tests++; fails++;
                $display("FAIL sb_cmd: unexpected cmd %0h addr %0h, none expected", af_cmd_din, addr_din);
            end else begin
                sb_c = cmd_q.pop_front();
                chk("sb_cmd", {af_cmd_din, addr_din}, sb_c);
            end
        end
        if (!rst && wdf_wr_en) begin
            if (wd_q.size() == 0) begin
                tests++; fails++;
                $display("FAIL sb_wdf: unexpected beat %0h, none expected", wdf_din);
            end else begin
                sb_w = wd_q.pop_front();
                chk("sb_wdf", {wdf_din, wdf_mask_din}, sb_w);
            end
        end
    end

    typedef struct {
        logic [N-1:0] req, rd, wvld;
        logic         afull, wfull;
        int           g;
        logic [N-1:0] e_af_full;
        logic         e_af_wr;
        logic [N-1:0] e_wdf_full;
        logic         e_wdf_wr;
        logic [N-1:0] e_m1_af_full;
    } vec_t;
    vec_t vt[8];

    initial begin
        vt[0] = '{4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 0, 4'b1110, 1'b0, 4'b1111, 1'b0, 4'b1110};
        vt[1] = '{4'b0100, 4'b0100, 4'b0000, 1'b0, 1'b0, 2, 4'b1011, 1'b1, 4'b1111, 1'b0, 4'b1011};
        vt[2] = '{4'b1010, 4'b0000, 4'b0010, 1'b0, 1'b0, 1, 4'b1101, 1'b1, 4'b1101, 1'b1, 4'b1101};
        vt[3] = '{4'b1001, 4'b1001, 4'b0000, 1'b1, 1'b0, 0, 4'b1111, 1'b0, 4'b1111, 1'b0, 4'b1111};
        vt[4] = '{4'b1000, 4'b1000, 4'b0000, 1'b0, 1'b0, 3, 4'b0111, 1'b1, 4'b1111, 1'b0, 4'b0111};
        vt[5] = '{4'b0100, 4'b0000, 4'b1000, 1'b0, 1'b0, 2, 4'b1011, 1'b1, 4'b1011, 1'b0, 4'b1011};
        vt[6] = '{4'b0010, 4'b0000, 4'b0010, 1'b0, 1'b1, 1, 4'b1101, 1'b1, 4'b1111, 1'b0, 4'b1101};
        vt[7] = '{4'b1100, 4'b1100, 4'b0000, 1'b0, 1'b0, 2, 4'b1011, 1'b1, 4'b1111, 1'b0, 4'b1011};

        for (int i = 0; i < N; i++) c_addr_din[i*AW +: AW] = AW'(i * 256);
        do_reset();

        @(negedge clk);
        chk("rst af_wr_en", af_wr_en, 0);
        chk("rst shared cmd/addr", {af_cmd_din, addr_din}, 0);
        chk("rst wdf", {wdf_wr_en, wdf_din, wdf_mask_din}, 0);
        chk("rst rdf_rd_en", rdf_rd_en, 0);
        chk("rst c_af_full", c_af_full, 4'b1110);
        chk("rst c_rdf_valid", c_rdf_valid, 0);
        chk("rst orphan_err", orphan_err, 0);
        next_cycle();

        for (int i = 0; i < 8; i++) begin
            do_reset();
            drive_req(vt[i].req, vt[i].rd);
            drive_wd(vt[i].wvld, 0);
            af_full  = vt[i].afull;
            wdf_full = vt[i].wfull;
            if (vt[i].e_af_wr)  exp_cmd(vt[i].g, vt[i].rd[vt[i].g]);
            if (vt[i].e_wdf_wr) exp_wd(vt[i].g, 0);
            @(negedge clk);
            chk($sformatf("vec%0d c_af_full", i), c_af_full, vt[i].e_af_full);
            chk($sformatf("vec%0d af_wr_en", i), af_wr_en, vt[i].e_af_wr);
            chk($sformatf("vec%0d c_wdf_full", i), c_wdf_full, vt[i].e_wdf_full);
            chk($sformatf("vec%0d wdf_wr_en", i), wdf_wr_en, vt[i].e_wdf_wr);
            chk($sformatf("vec%0d m1 c_af_full", i), m1_c_af_full, vt[i].e_m1_af_full);
            next_cycle();
        end

        // Reads from 0,1,2 accepted in order; bursts come back in the same order.
        do_reset();
        drive_req(4'b0111, 4'b0111); exp_cmd(0, 1'b1);
        @(negedge clk); chk("rd_order grant0", c_af_full, 4'b1110); next_cycle();
        drive_req(4'b0110, 4'b0110); exp_cmd(1, 1'b1);
        @(negedge clk); chk("rd_order grant1", c_af_full, 4'b1101); next_cycle();
        drive_req(4'b0100, 4'b0100); exp_cmd(2, 1'b1);
        @(negedge clk); chk("rd_order grant2", c_af_full, 4'b1011); next_cycle();
        drive_req(4'b0000, 4'b0000);
        rdf_valid = 1'b1; c_rdf_rd_en = 4'b1111;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk($sformatf("tag_ret%0d c_rdf_valid", k), c_rdf_valid, 4'(1 << (k / 2)));
            chk($sformatf("tag_ret%0d rdf_rd_en", k), rdf_rd_en, 1);
            next_cycle();
        end
        clear_inputs();

        // Write lock: client 1 writes while client 3 waits with a read.
        do_reset();
        drive_req(4'b1010, 4'b1000); exp_cmd(1, 1'b0);
        @(negedge clk); chk("wlock accept", c_af_full, 4'b1101); next_cycle();
        drive_req(4'b1000, 4'b1000); drive_wd(4'b1010, 0); exp_wd(1, 0);
        @(negedge clk);
        chk("wlock beat0 c_af_full", c_af_full, 4'b1111);
        chk("wlock beat0 c_wdf_full", c_wdf_full, 4'b1101);
        next_cycle();
        wdf_full = 1'b1; drive_wd(4'b1010, 1);
        @(negedge clk);
        chk("wlock stall c_wdf_full", c_wdf_full, 4'b1111);
        chk("wlock stall wdf_wr_en", wdf_wr_en, 0);
        next_cycle();
        wdf_full = 1'b0; exp_wd(1, 1);
        @(negedge clk);
        chk("wlock beat1 c_af_full", c_af_full, 4'b1111);
        chk("wlock beat1 wdf_wr_en", wdf_wr_en, 1);
        next_cycle();
        drive_wd(4'b0000, 0); exp_cmd(3, 1'b1);
        @(negedge clk); chk("wlock release read3", c_af_full, 4'b0111); next_cycle();
        clear_inputs();

        // Reads by 2 then 0: return beats steered to 2 first, then 0.
        do_reset();
        drive_req(4'b0100, 4'b0100); exp_cmd(2, 1'b1);
        @(negedge clk); chk("ret grant2", c_af_full, 4'b1011); next_cycle();
        drive_req(4'b0001, 4'b0001); exp_cmd(0, 1'b1);
        @(negedge clk); chk("ret grant0", c_af_full, 4'b1110); next_cycle();
        drive_req(4'b0000, 4'b0000);
        rdf_valid = 1'b1; c_rdf_rd_en = 4'b0001;
        @(negedge clk);
        chk("ret wrong popper c_rdf_valid", c_rdf_valid, 4'b0100);
        chk("ret wrong popper rdf_rd_en", rdf_rd_en, 0);
        next_cycle();
        c_rdf_rd_en = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("ret%0d c_rdf_valid", k), c_rdf_valid, (k < 2) ? 4'b0100 : 4'b0001);
            chk($sformatf("ret%0d rdf_rd_en", k), rdf_rd_en, 1);
            next_cycle();
        end
        rdf_valid = 1'b0;
        @(negedge clk); chk("ret orphan_err", orphan_err, 0); next_cycle();
        clear_inputs();

        // Tag FIFO full: 9th read stalls, a write still goes, read accepted on dequeue.
        do_reset();
        drive_req(4'b0001, 4'b0001);
        for (int k = 0; k < 8; k++) begin
            exp_cmd(0, 1'b1);
            @(negedge clk); chk($sformatf("tagfill%0d", k), c_af_full, 4'b1110); next_cycle();
        end
        drive_req(4'b0101, 4'b0001); drive_wd(4'b0100, 0);
        exp_cmd(2, 1'b0); exp_wd(2, 0);
        @(negedge clk); chk("tagfull write accepted", c_af_full, 4'b1011); next_cycle();
        drive_req(4'b0001, 4'b0001); drive_wd(4'b0100, 1); exp_wd(2, 1);
        @(negedge clk); chk("tagfull wlock", c_af_full, 4'b1111); next_cycle();
        drive_wd(4'b0000, 0);
        @(negedge clk); chk("tagfull read stalls", c_af_full, 4'b1111); next_cycle();
        rdf_valid = 1'b1; c_rdf_rd_en = 4'b0001;
        @(negedge clk);
        chk("tagfull first beat stall", c_af_full, 4'b1111);
        chk("tagfull c_rdf_valid", c_rdf_valid, 4'b0001);
        next_cycle();
        exp_cmd(0, 1'b1);
        @(negedge clk);
        chk("tagfull accept on dequeue", c_af_full, 4'b1110);
        chk("tagfull af_wr_en", af_wr_en, 1);
        next_cycle();
        clear_inputs();

        // Orphan read data.
        do_reset();
        rdf_valid = 1'b1; c_rdf_rd_en = 4'b1111;
        @(negedge clk);
        chk("orphan rdf_rd_en", rdf_rd_en, 0);
        chk("orphan c_rdf_valid", c_rdf_valid, 0);
        chk("orphan err before edge", orphan_err, 0);
        next_cycle();
        rdf_valid = 1'b0; c_rdf_rd_en = 4'b0000;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); chk($sformatf("orphan sticky%0d", k), orphan_err, 1); next_cycle();
        end
        do_reset();
        @(negedge clk); chk("orphan cleared by rst", orphan_err, 0); next_cycle();

        // Clients 0 and 3 reading continuously: mode 1 always 0, mode 0 alternates.
        do_reset();
        drive_req(4'b1001, 4'b1001);
        for (int k = 0; k < 6; k++) begin
            exp_cmd((k % 2 == 0) ? 0 : 3, 1'b1);
            @(negedge clk);
            chk($sformatf("prio m1 cycle%0d", k), m1_c_af_full, 4'b1110);
            chk($sformatf("prio rr cycle%0d", k), c_af_full, (k % 2 == 0) ? 4'b1110 : 4'b0111);
            next_cycle();
        end
        clear_inputs();

        // Reset in the middle of a locked write, then a clean new write.
        do_reset();
        drive_req(4'b0010, 4'b0000); exp_cmd(1, 1'b0);
        @(negedge clk); chk("rstmid accept", c_af_full, 4'b1101); next_cycle();
        drive_req(4'b0000, 4'b0000); drive_wd(4'b0010, 0); exp_wd(1, 0);
        @(negedge clk); chk("rstmid beat0", c_wdf_full, 4'b1101); next_cycle();
        do_reset();
        @(negedge clk);
        chk("rstmid idle c_af_full", c_af_full, 4'b1110);
        chk("rstmid idle c_wdf_full", c_wdf_full, 4'b1111);
        next_cycle();
        drive_req(4'b0100, 4'b0000); drive_wd(4'b0100, 0);
        exp_cmd(2, 1'b0); exp_wd(2, 0);
        @(negedge clk);
        chk("rstmid new write c_af_full", c_af_full, 4'b1011);
        chk("rstmid new write c_wdf_full", c_wdf_full, 4'b1011);
        next_cycle();
        drive_req(4'b0000, 4'b0000); drive_wd(4'b0100, 1); exp_wd(2, 1);
        @(negedge clk); chk("rstmid beat1", c_wdf_full, 4'b1011); next_cycle();
        drive_wd(4'b0000, 0);
        @(negedge clk);
        chk("rstmid done c_af_full", c_af_full, 4'b0111);
        chk("rstmid done c_wdf_full", c_wdf_full, 4'b1111);
        next_cycle();
        clear_inputs();

        @(negedge clk);
        chk("sb_cmd drained", cmd_q.size(), 0);
        chk("sb_wdf drained", wd_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
